// File: rtl/pwm_core.sv
// Prescaled PWM generator with shadowed period/duty/prescale registers that
// swap in at period boundaries, optional one-shot mode and a period interrupt.
module pwm_core #(
  parameter int C_CNT_WIDTH = 32,
  parameter int C_PRE_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   ctrl_enable,
  input  logic                   ctrl_invert,
  input  logic                   ctrl_oneshot,
  input  logic [C_CNT_WIDTH-1:0] period_in,
  input  logic [C_CNT_WIDTH-1:0] duty_in,
  input  logic [C_PRE_WIDTH-1:0] prescale_in,
  input  logic                   update_req,
  output logic                   pwm_out,
  output logic                   period_irq,
  output logic                   done_o,
  output logic [C_CNT_WIDTH-1:0] cnt_o,
  output logic                   pending_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [C_CNT_WIDTH-1:0] r_cnt;
  logic [C_PRE_WIDTH-1:0] r_pre;
  logic [C_CNT_WIDTH-1:0] r_period_act;
  logic [C_CNT_WIDTH-1:0] r_duty_act;
  logic [C_PRE_WIDTH-1:0] r_prescale_act;
  logic                   r_pending;
  logic                   r_pwm;
  logic                   r_irq;
  logic                   r_done;
  logic                   w_tick;
  logic                   w_term;

  assign w_tick = (r_pre == r_prescale_act);
  // A terminal tick only counts while the block keeps running this cycle.
  assign w_term = (r_state == S_RUN) && ctrl_enable && w_tick && (r_cnt == r_period_act);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (ctrl_enable) w_state_next = S_RUN;
      S_RUN: begin
        if (!ctrl_enable) w_state_next = S_IDLE;
        else if (w_term && ctrl_oneshot) w_state_next = S_DONE;
      end
      S_DONE: if (!ctrl_enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt          <= '0;
      r_pre          <= '0;
      r_period_act   <= '0;
      r_duty_act     <= '0;
      r_prescale_act <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= 1'b0;
      r_irq          <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_irq <= w_term;
      r_pwm <= ((r_state == S_RUN) && (r_cnt < r_duty_act)) ^ ctrl_invert;
      if (update_req) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_pre <= '0;
          if (ctrl_enable) begin
            r_period_act   <= period_in;
            r_duty_act     <= duty_in;
            r_prescale_act <= prescale_in;
            r_pending      <= 1'b0;
          end
        end
        S_RUN: begin
          if (!ctrl_enable) begin
            r_cnt <= '0;
            r_pre <= '0;
          end else if (w_tick) begin
            r_pre <= '0;
            if (r_cnt == r_period_act) begin
              r_cnt <= '0;
              // Shadow swap; a request landing on this very tick is taken too.
              if (r_pending || update_req) begin
                r_period_act   <= period_in;
                r_duty_act     <= duty_in;
                r_prescale_act <= prescale_in;
                r_pending      <= 1'b0;
              end
              if (ctrl_oneshot) r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_CNT_WIDTH'(1);
            end
          end else begin
            r_pre <= r_pre + C_PRE_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_cnt <= '0;
          r_pre <= '0;
          if (!ctrl_enable) r_done <= 1'b0;
        end
        default: begin
          r_cnt <= '0;
          r_pre <= '0;
        end
      endcase
    end
  end

  assign pwm_out    = r_pwm;
  assign period_irq = r_irq;
  assign done_o     = r_done;
  assign cnt_o      = r_cnt;
  assign pending_o  = r_pending;

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: waveform shapes, prescaling, shadow updates,
// duty extremes with inversion, one-shot mode and asynchronous reset.
module tb_pwm_core;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          ctrl_enable;
  logic          ctrl_invert;
  logic          ctrl_oneshot;
  logic [CW-1:0] period_in;
  logic [CW-1:0] duty_in;
  logic [PW-1:0] prescale_in;
  logic          update_req;
  logic          pwm_out;
  logic          period_irq;
  logic          done_o;
  logic [CW-1:0] cnt_o;
  logic          pending_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] cap_pwm;
  logic [63:0] cap_irq;
  logic [63:0] cap_cnt;

  pwm_core #(.C_CNT_WIDTH(CW), .C_PRE_WIDTH(PW)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ctrl_enable (ctrl_enable),
    .ctrl_invert (ctrl_invert),
    .ctrl_oneshot(ctrl_oneshot),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .prescale_in (prescale_in),
    .update_req  (update_req),
    .pwm_out     (pwm_out),
    .period_irq  (period_irq),
    .done_o      (done_o),
    .cnt_o       (cnt_o),
    .pending_o   (pending_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Shift one sample per clock so the oldest sample ends up leftmost.
  task automatic capture(input int n);
    cap_pwm = '0;
    cap_irq = '0;
    cap_cnt = '0;
    repeat (n) begin
      step(1);
      cap_pwm = {cap_pwm[62:0], pwm_out};
      cap_irq = {cap_irq[62:0], period_irq};
      cap_cnt = {cap_cnt[59:0], cnt_o[3:0]};
    end
  endtask

  // Drop to IDLE, load new settings, then enable; returns just after the enable edge.
  task automatic start(input logic [CW-1:0] per, input logic [CW-1:0] dty, input logic [PW-1:0] pre);
    ctrl_enable = 1'b0;
    step(2);
    check("idle_cnt", cnt_o, 0);
    check("idle_pwm", pwm_out, ctrl_invert);
    period_in   = per;
    duty_in     = dty;
    prescale_in = pre;
    ctrl_enable = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ARESETN      = 1'b0;
    ctrl_enable  = 1'b0;
    ctrl_invert  = 1'b1;
    ctrl_oneshot = 1'b0;
    period_in    = '0;
    duty_in      = '0;
    prescale_in  = '0;
    update_req   = 1'b0;
    step(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_irq", period_irq, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_pending", pending_o, 0);
    #2 ARESETN = 1'b1;
    step(1);
    check("idle_inv_pwm", pwm_out, 1);
    ctrl_invert = 1'b0;

    // period 10, duty 3, no prescale
    start(9, 3, 0);
    check("p10_cnt0", cnt_o, 0);
    capture(20);
    check("p10_pwm", cap_pwm, 64'b11100000001110000000);
    check("p10_irq", cap_irq, 64'b00000000010000000001);
    check("p10_cnt", cap_cnt, 64'h5678901234567890);

    // prescale by 2: period 8 clocks, high 4
    start(3, 2, 1);
    capture(16);
    check("pre_pwm", cap_pwm, 64'b1111000011110000);
    check("pre_irq", cap_irq, 64'b0000000100000001);
    check("pre_cnt", cap_cnt, 64'h0112233001122330);

    // shadowed duty update mid-period, then one coincident with the terminal tick
    start(9, 3, 0);
    step(4);
    check("upd_cnt4", cnt_o, 4);
    duty_in    = 7;
    update_req = 1'b1;
    step(1);
    update_req = 1'b0;
    check("upd_pending", pending_o, 1);
    check("upd_old_duty_a", pwm_out, 0);
    step(1);
    check("upd_old_duty_b", pwm_out, 0);
    step(3);
    check("upd_pending_hold", pending_o, 1);
    step(1);
    check("upd_pending_clr", pending_o, 0);
    check("upd_irq", period_irq, 1);
    capture(9);
    check("upd_new_duty", cap_pwm, 64'b111111100);
    check("upd_cnt9", cnt_o, 9);
    duty_in    = 3;
    update_req = 1'b1;
    step(1);
    update_req = 1'b0;
    check("coin_pending", pending_o, 0);
    check("coin_irq", period_irq, 1);
    capture(10);
    check("coin_pwm", cap_pwm, 64'b1110000000);

    // duty extremes, normal and inverted
    start(9, 0, 0);
    capture(20);
    check("duty0_pwm", cap_pwm, 64'h0);
    start(9, 10, 0);
    capture(20);
    check("dutyfull_pwm", cap_pwm, 64'hFFFFF);
    ctrl_invert = 1'b1;
    capture(20);
    check("dutyfull_inv_pwm", cap_pwm, 64'h0);
    start(9, 0, 0);
    capture(20);
    check("duty0_inv_pwm", cap_pwm, 64'hFFFFF);
    ctrl_invert = 1'b0;

    // one-shot
    ctrl_oneshot = 1'b1;
    start(4, 2, 0);
    capture(10);
    check("os_pwm", cap_pwm, 64'b1100000000);
    check("os_irq", cap_irq, 64'b0000100000);
    check("os_done", done_o, 1);
    check("os_cnt", cnt_o, 0);
    ctrl_enable = 1'b0;
    step(1);
    check("os_done_clr", done_o, 0);
    step(1);
    check("os_idle_pwm", pwm_out, 0);
    check("os_idle_cnt", cnt_o, 0);
    ctrl_oneshot = 1'b0;

    // asynchronous reset mid-period
    start(9, 7, 0);
    step(5);
    check("ar_cnt5", cnt_o, 5);
    check("ar_pwm_pre", pwm_out, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("ar_async_pwm", pwm_out, 0);
    check("ar_async_cnt", cnt_o, 0);
    step(1);
    check("ar_hold_cnt", cnt_o, 0);
    check("ar_hold_pwm", pwm_out, 0);
    #1 ARESETN = 1'b1;
    step(1);
    check("ar_restart_cnt", cnt_o, 0);
    check("ar_restart_pwm", pwm_out, 0);
    capture(10);
    check("ar_fresh_pwm", cap_pwm, 64'b1111111000);
    check("ar_fresh_cnt", cap_cnt, 64'h1234567890);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
